// File: rtl/nms_window_buffer.sv
// Streaming 3x3 {dir,mag} window generator feeding the Canny NMS stage.
// Optional NMS_WIN_SOF_EN adds sof resync and a sticky frame_err flag.
module nms_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] mag_in,
  input  logic [1:0]  dir_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [98:0] Gradiant_Magnitude_Data,
  output logic [17:0] Direction_Data,
  output logic        Gradiant_Magnitude_in_valid,
  output logic        Direction_Data_in_valid,
`ifdef NMS_WIN_SOF_EN
  input  logic        sof,
  output logic        frame_err,
`endif
  input  logic        out_ready
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PW = 13;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;

  // lb1 holds row-1, lb2 holds row-2, both addressed by column
  logic [PW-1:0] lb1_mem [IMG_WIDTH];
  logic [PW-1:0] lb2_mem [IMG_WIDTH];
  logic [PW-1:0] lb1_rd, lb2_rd, pix;

  // win[r][c]: r=0 oldest row, c=0 oldest column
  logic [2:0][2:0][PW-1:0] win_q, win_d;

  logic        out_vld_q, out_vld_d;
  logic [98:0] mag_q, mag_d;
  logic [17:0] dir_q, dir_d;
  logic        accept, emit;

  assign in_ready = !out_vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pix      = {dir_in, mag_in};

`ifdef NMS_WIN_SOF_EN
  logic err_q, err_d;

  assign col_eff = sof ? '0 : col_q;
  assign row_eff = sof ? '0 : row_q;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      if (sof && (col_q != '0 || row_q != '0)) err_d = 1'b1;
      if (!sof && col_q == '0 && row_q == '0)  err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign frame_err = err_q;
`else
  assign col_eff = col_q;
  assign row_eff = row_q;
`endif

  assign lb1_rd = lb1_mem[col_eff];
  assign lb2_rd = lb2_mem[col_eff];

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    out_vld_d = out_vld_q;
    mag_d     = mag_q;
    dir_d     = dir_q;
    emit      = 1'b0;

    if (out_ready) out_vld_d = 1'b0;

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = pix;

      // col>=2 also rejects windows that would straddle a row wrap
      emit = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);

      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end

    if (emit) begin
      out_vld_d = 1'b1;
      for (int k = 0; k < 9; k++) begin
        mag_d[11*k +: 11] = win_d[k/3][k%3][10:0];
        dir_d[2*k +: 2]   = win_d[k/3][k%3][12:11];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      out_vld_q <= 1'b0;
      mag_q     <= '0;
      dir_q     <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      out_vld_q <= out_vld_d;
      mag_q     <= mag_d;
      dir_q     <= dir_d;
    end
  end

  // Contents need no reset: the row/col gate hides anything stale
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_eff] <= pix;
      lb2_mem[col_eff] <= lb1_rd;
    end
  end

  assign Gradiant_Magnitude_Data     = mag_q;
  assign Direction_Data              = dir_q;
  assign Gradiant_Magnitude_in_valid = out_vld_q;
  assign Direction_Data_in_valid     = out_vld_q;

endmodule

// File: tb/tb_nms_window_buffer.sv
// Self-checking bench for nms_window_buffer on a 5x4 image; windows are
// predicted by cutting 3x3 tiles out of a stored copy of the frame.
`timescale 1ns/1ps
module tb_nms_window_buffer;
  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] mag_in = '0;
  logic [1:0]  dir_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_ready = 1'b1;
  logic [98:0] gm;
  logic [17:0] dd;
  logic        gm_vld, dd_vld;
`ifdef NMS_WIN_SOF_EN
  logic        sof = 1'b0;
  logic        frame_err;
`endif

  nms_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .mag_in(mag_in), .dir_in(dir_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .Gradiant_Magnitude_Data(gm), .Direction_Data(dd),
    .Gradiant_Magnitude_in_valid(gm_vld), .Direction_Data_in_valid(dd_vld),
`ifdef NMS_WIN_SOF_EN
    .sof(sof), .frame_err(frame_err),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [98:0] mag;
    logic [17:0] dir;
    int          cyc;
  } win_t;

  win_t        exp_q[$];
  logic [12:0] img [H][W];
  int          m_row, m_col, acc_cnt, cyc, obs_cyc;
  int          checks, errors;
  bit          use_pat;
  logic        obs_rdy, obs_vld, obs_vld2;
  logic [98:0] obs_mag;
  logic [17:0] obs_dir;
  int          exp_c[6] = '{6, 7, 8, 11, 12, 13};

  // Reference: a window is the 3x3 tile of the frame ending at the accepted pixel
  task automatic model_accept(input logic [10:0] m, input logic [1:0] d, input logic s);
    win_t w;
    logic [12:0] p;
    int k;
    if (s) begin m_row = 0; m_col = 0; end
    img[m_row][m_col] = {d, m};
    if (m_row >= 2 && m_col >= 2) begin
      w.mag = '0; w.dir = '0; w.cyc = cyc;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          k = 3 * r + c;
          p = img[m_row - 2 + r][m_col - 2 + c];
          w.mag[11*k +: 11] = p[10:0];
          w.dir[2*k +: 2]   = p[12:11];
        end
      exp_q.push_back(w);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end
    acc_cnt++;
  endtask

  // Drive one cycle, sample at the falling edge, advance to just after the rising edge
  task automatic cycle(input logic v, input logic force_sof, input logic ordy);
    logic [10:0] m;
    logic [1:0]  d;
    logic        s;
    int          pr, pc;
    s  = force_sof || (m_row == 0 && m_col == 0);
    pr = force_sof ? 0 : m_row;
    pc = force_sof ? 0 : m_col;
    if (use_pat) begin
      m = 11'(pr * 5 + pc);
      d = 2'(pc);
    end else begin
      m = 11'($urandom);
      d = 2'($urandom);
    end
    in_valid = v; mag_in = m; dir_in = d; out_ready = ordy;
`ifdef NMS_WIN_SOF_EN
    sof = s;
`endif
    @(negedge clk);
    obs_rdy = in_ready; obs_vld = gm_vld; obs_vld2 = dd_vld;
    obs_mag = gm; obs_dir = dd; obs_cyc = cyc;
    if (v && obs_rdy) model_accept(m, d, s);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_row = 0; m_col = 0; acc_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || gm_vld !== 1'b0 || dd_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b vld=%b/%b, need 1/0/0", in_ready, gm_vld, dd_vld);
    end
    checks++;
    if (gm !== '0 || dd !== '0) begin
      errors++;
      $display("FAIL reset_data: mag=%h dir=%h, need 0", gm, dd);
    end
`ifdef NMS_WIN_SOF_EN
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: frame_err=%b need 0", frame_err); end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream(input string name, input int frames);
    int cen[$];
    use_pat = 1;
    do_reset();
    for (int i = 0; i < frames * W * H + 3; i++) begin
      cycle(i < frames * W * H, 1'b0, 1'b1);
      checks++;
      if (obs_vld2 !== obs_vld) begin
        errors++; $display("FAIL %s_vld_pair: dir_vld=%b mag_vld=%b", name, obs_vld2, obs_vld);
      end
      if (obs_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_spurious: window mag=%h, none expected", name, obs_mag);
        end else begin
          if (obs_mag !== exp_q[0].mag || obs_dir !== exp_q[0].dir) begin
            errors++;
            $display("FAIL %s_window: mag=%h dir=%h, need mag=%h dir=%h",
                     name, obs_mag, obs_dir, exp_q[0].mag, exp_q[0].dir);
          end
          checks++;
          if (obs_cyc != exp_q[0].cyc + 1) begin
            errors++; $display("FAIL %s_latency: seen cycle %0d, need %0d", name, obs_cyc, exp_q[0].cyc + 1);
          end
          if (cen.size() == 0) begin
            checks++;
            if (obs_mag[10:0] !== 11'd0 || obs_mag[54:44] !== 11'd6 || obs_mag[98:88] !== 11'd12
                || obs_dir[9:8] !== 2'd1) begin
              errors++;
              $display("FAIL %s_first: tl=%0d ctr=%0d br=%0d dirc=%0d, need 0/6/12/1", name,
                       obs_mag[10:0], obs_mag[54:44], obs_mag[98:88], obs_dir[9:8]);
            end
          end
          exp_q.pop_front();
        end
        cen.push_back(int'(obs_mag[54:44]));
      end
    end
    checks++;
    if (cen.size() != 6 * frames || exp_q.size() != 0) begin
      errors++; $display("FAIL %s_count: %0d windows, need %0d", name, cen.size(), 6 * frames);
    end
    for (int i = 0; i < cen.size() && i < 6 * frames; i++) begin
      checks++;
      if (cen[i] != exp_c[i % 6]) begin
        errors++; $display("FAIL %s_centre: window %0d centre %0d, need %0d", name, i, cen[i], exp_c[i % 6]);
      end
    end
  endtask

  task automatic test_backpressure();
    int   stall, cen0;
    logic ordy, prev_hold;
    logic [98:0] prev_mag;
    logic [17:0] prev_dir;
    use_pat = 1;
    do_reset();
    stall = 0; cen0 = -1; prev_hold = 0; prev_mag = '0; prev_dir = '0;
    // Phase 1: pattern frame, 4 stall cycles on the first window
    // Phase 2: random data, random valid and ready for two more frames
    for (int i = 0; i < 600 && !(acc_cnt >= 3 * W * H && exp_q.size() == 0); i++) begin
      if (acc_cnt >= W * H) use_pat = 0;
      if (use_pat) ordy = !(stall < 4 && exp_q.size() > 0);
      else         ordy = 1'($urandom_range(0, 1));
      cycle(use_pat ? (acc_cnt < W * H) : ((acc_cnt < 3 * W * H) && $urandom_range(0, 2) != 0),
            1'b0, ordy);
      if (use_pat && !ordy) begin
        stall++;
        checks++;
        if (obs_vld !== 1'b1 || obs_rdy !== 1'b0) begin
          errors++; $display("FAIL bp_stall: vld=%b in_ready=%b, need 1/0", obs_vld, obs_rdy);
        end
      end
      if (prev_hold) begin
        checks++;
        if (obs_vld !== 1'b1 || obs_mag !== prev_mag || obs_dir !== prev_dir) begin
          errors++; $display("FAIL bp_hold: vld=%b mag=%h, need 1 and %h", obs_vld, obs_mag, prev_mag);
        end
      end
      prev_hold = obs_vld && !ordy;
      prev_mag = obs_mag; prev_dir = obs_dir;
      if (obs_vld && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_spurious: window mag=%h, none expected", obs_mag);
        end else begin
          if (obs_mag !== exp_q[0].mag || obs_dir !== exp_q[0].dir) begin
            errors++;
            $display("FAIL bp_window: mag=%h dir=%h, need mag=%h dir=%h",
                     obs_mag, obs_dir, exp_q[0].mag, exp_q[0].dir);
          end
          if (cen0 < 0) cen0 = int'(obs_mag[54:44]);
          exp_q.pop_front();
        end
      end
    end
    checks++;
    if (stall != 4 || cen0 != 6) begin
      errors++; $display("FAIL bp_first: stalls=%0d first centre=%0d, need 4 and 6", stall, cen0);
    end
    checks++;
    if (acc_cnt < 3 * W * H || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_timeout: beats=%0d pending=%0d, need %0d and 0", acc_cnt, exp_q.size(), 3 * W * H);
    end
  endtask

  task automatic test_reset_midframe();
    use_pat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    m_row = 0; m_col = 0; acc_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (gm_vld !== 1'b0 || gm !== '0) begin
      errors++; $display("FAIL midrst_clear: vld=%b mag=%h, need 0", gm_vld, gm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_toggle();
    int n;
    use_pat = 0;
    do_reset();
    n = 0;
    for (int i = 0; i < 4 * W * H + 4; i++) begin
      cycle(i[0] == 1'b0 && i < 4 * W * H, 1'b0, 1'b1);
      if (obs_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL toggle_spurious: window mag=%h, none expected", obs_mag);
        end else begin
          if (obs_mag !== exp_q[0].mag || obs_dir !== exp_q[0].dir || obs_cyc != exp_q[0].cyc + 1) begin
            errors++;
            $display("FAIL toggle_window: mag=%h cyc=%0d, need mag=%h cyc=%0d",
                     obs_mag, obs_cyc, exp_q[0].mag, exp_q[0].cyc + 1);
          end
          exp_q.pop_front();
          n++;
        end
      end
    end
    checks++;
    if (n != 12 || exp_q.size() != 0) begin
      errors++; $display("FAIL toggle_count: %0d windows, need 12", n);
    end
  endtask

`ifdef NMS_WIN_SOF_EN
  task automatic test_sof();
    int n, after;
    use_pat = 1;
    do_reset();
    n = 0; after = -1;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL sof_early: frame_err=%b need 0", frame_err); end
    cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL sof_err: frame_err=%b need 1", frame_err); end
    for (int i = 0; i < 14; i++) begin
      cycle(i < 12, 1'b0, 1'b1);
      if (obs_vld) begin
        checks++;
        if (exp_q.size() == 0 || obs_mag !== exp_q[0].mag || obs_mag[54:44] !== 11'd6) begin
          errors++; $display("FAIL sof_window: mag=%h centre=%0d, need centre 6", obs_mag, obs_mag[54:44]);
        end
        if (exp_q.size() != 0) exp_q.pop_front();
        if (after < 0) after = i + 1;
        n++;
      end
    end
    checks++;
    if (after != 13 || n != 1 || frame_err !== 1'b1) begin
      errors++; $display("FAIL sof_resync: window after %0d beats, %0d windows, need 13 and 1", after, n);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0; use_pat = 1;
    m_row = 0; m_col = 0; acc_cnt = 0;
    test_reset();
    test_stream("stream", 1);
    test_backpressure();
    test_stream("b2b", 2);
    test_reset_midframe();
    test_stream("postrst", 1);
    test_toggle();
`ifdef NMS_WIN_SOF_EN
    test_sof();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nms_window_buffer.md
# nms_window_buffer

- Streaming 3x3 window generator directly upstream of the non-max-suppression stage in the Canny edge pipeline.
- Takes one gradient-magnitude pixel (11 b) and its quantised direction (2 b) per accepted beat, in raster order.
- Holds the two previous image rows in line buffers.
- Emits the packed 99-bit magnitude window and 18-bit direction window that the NMS stage consumes, with a valid/ready handshake and backpressure.

## Interface
- IMG_WIDTH, 640, pixels per row (>=3)
- IMG_HEIGHT, 480, rows per frame (>=3)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mag_in  input  11  gradient magnitude, unsigned
- dir_in  input  2  quantised direction code
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat
- Gradiant_Magnitude_Data  output  99  3x3 magnitude window
- Direction_Data  output  18  3x3 direction window
- Gradiant_Magnitude_in_valid  output  1  window valid
- Direction_Data_in_valid  output  1  window valid, identical to Gradiant_Magnitude_in_valid
- out_ready  input  1  downstream accepts window
- sof  input  1  start of frame (only with NMS_WIN_SOF_EN)
- frame_err  output  1  sticky sync error (only with NMS_WIN_SOF_EN)

## Operation
- Beat accepted when in_valid && in_ready.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance per accepted beat.
  - col wraps to 0 and increments row.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- Two line buffers, each IMG_WIDTH x 13 b ({dir,mag}), hold rows row-1 and row-2 at column col.
  - Read and write at address col on each accepted beat.
- The 3x3 shift window shifts left one column per accepted beat.
  - New right column = {linebuf2[col], linebuf1[col], current pixel}.
- Window packing: position k = 3*r + c, with r=0 the oldest row (top) and c=0 the oldest column (left).
  - Magnitude for position k at bits [11k+10:11k]; centre at [54:44].
  - Direction for position k at [2k+1:2k]; centre at [9:8].
- Output is produced only when the accepted beat has row>=2 and col>=2.
  - Window is centred on pixel (row-1, col-1).
  - No border padding: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Windows whose left columns straddle a row wrap are never emitted, because the col>=2 gate covers this.
- Output register is one stage. in_ready = !out_valid || out_ready.
- Output data and valid hold stable while valid && !out_ready.
- Line buffer contents need no reset: rows 0-1 and columns 0-1 are gated.

## Timing
- Latency: window is visible on the cycle after the beat that completes it is accepted.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous output pop and input accept in one cycle are allowed, with no bubble.
- Reset values:
  - in_ready=1 from the first cycle after reset deasserts.
  - valids=0; data outputs=0; col=row=0; window registers=0.
  - frame_err=0.
- Reset mid-frame aborts the frame. The next accepted beat is pixel (0,0).
- Backpressure stalls counters and line buffers; no beat is lost or duplicated.

## Configuration
- NMS_WIN_SOF_EN defined:
  - sof and frame_err ports exist.
  - When a beat is accepted with sof=1, that beat is treated as (0,0) and counters resynchronise.
  - If the beat was not at (0,0), frame_err is set. It stays set until reset.
  - When a beat is accepted at (0,0) with sof=0, frame_err is also set.
- Not defined: no sof/frame_err ports; counters free-run from reset.

## Test plan
All scenarios use IMG_WIDTH=5 and IMG_HEIGHT=4; mag_in = r*5+c and dir_in = c[1:0] unless stated.
- Continuous stream, out_ready=1: first window appears the cycle after beat 12 is accepted.
  - Mag [10:0]=0, [54:44]=6, [98:88]=12.
  - Dir [9:8]=1.
  - Exactly 6 windows per frame, centres 6,7,8,11,12,13.
- out_ready=0 for 4 cycles after the first window:
  - Output is held constant.
  - in_ready=0 while full.
  - Resume yields centres 7,8,11,12,13 with none lost.
- Back-to-back frames: second frame yields the identical 6 windows, with none spanning the frame boundary.
- Assert reset after beat 9, then restart the frame: output matches scenario 1 exactly, with no stale window.
- in_valid toggled every other cycle: same 6 windows in order, each 1 cycle after its completing beat.
- With NMS_WIN_SOF_EN: sof at beat 7 → frame_err=1 and counters restart. The next window appears after 13 further beats, centre value matching the new numbering.
